// File: rtl/neuron_step_scheduler.sv
// Time-step sequencer: walks every neuron through the shared update datapath once per step.
// Optional per-neuron refractory skipping is compiled in with `define NEURO_SCHED_REFRACTORY_EN.
module neuron_step_scheduler #(
    parameter int NUM_NEURONS  = 8,
    parameter int IDX_W        = 3,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   step_req,
    output logic                   busy,
    output logic                   upd_valid,
    output logic [IDX_W-1:0]       upd_idx,
    input  logic                   upd_ready,
    input  logic                   res_valid,
    input  logic                   res_spike,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic [IDX_W:0]         spike_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_NEURONS-1:0] pend_q, pend_d;
    logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [IDX_W:0]         spike_cnt_q, spike_cnt_d;
    logic                   skip;
    logic                   advance;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_NEURONS-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt = cnt + (IDX_W+1)'(v[i]);
        end
        return cnt;
    endfunction

`ifdef NEURO_SCHED_REFRACTORY_EN
    localparam logic [2:0] REFRAC_LOAD = 3'(REFRAC_STEPS);

    logic [NUM_NEURONS-1:0] ref_nz;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_ref
            logic [2:0] ref_q, ref_d;
            logic       sel;

            assign sel       = (idx_q == IDX_W'(gi));
            assign ref_nz[gi] = (ref_q != 3'd0);

            // A skipped visit burns one refractory step; a captured spike reloads it.
            always_comb begin
                ref_d = ref_q;
                if (state_q == S_ISSUE && sel && ref_q != 3'd0) begin
                    ref_d = ref_q - 3'd1;
                end else if (state_q == S_WAIT && sel && res_valid && res_spike) begin
                    ref_d = REFRAC_LOAD;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ref_q <= 3'd0;
                end else begin
                    ref_q <= ref_d;
                end
            end
        end
    endgenerate

    assign skip = (state_q == S_ISSUE) && ref_nz[idx_q];
`else
    logic unused_refrac;
    assign unused_refrac = |3'(REFRAC_STEPS);
    assign skip          = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        spike_vec_d = spike_vec_q;
        spike_cnt_d = spike_cnt_q;
        advance     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (step_req && ena) begin
                    pend_d  = '0;
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (skip) begin
                    pend_d[idx_q] = 1'b0;
                    advance       = 1'b1;
                end else if (upd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    pend_d[idx_q] = res_spike;
                    advance       = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are latched on the edge into DONE so they are visible alongside step_done.
        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d     = S_DONE;
                spike_vec_d = pend_d;
                spike_cnt_d = popcount(pend_d);
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            pend_q      <= '0;
            spike_vec_q <= '0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            spike_vec_q <= spike_vec_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign upd_valid = (state_q == S_ISSUE) && !skip;
    assign upd_idx   = idx_q;
    assign step_done = (state_q == S_DONE);
    assign spike_vec = spike_vec_q;
    assign spike_cnt = spike_cnt_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Directed scoreboard bench for neuron_step_scheduler; acts as the update datapath.
// Refractory steps are exercised when NEURO_SCHED_REFRACTORY_EN is defined.
module tb_neuron_step_scheduler;

    localparam int N      = 8;
    localparam int REFRAC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       step_req = 1'b0;
    logic       upd_ready = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_spike = 1'b0;
    logic       busy, upd_valid, step_done;
    logic [2:0] upd_idx;
    logic [7:0] spike_vec;
    logic [3:0] spike_cnt;

    int         n_pass = 0;
    int         n_total = 0;
    int         exp_idx_q[$];
    logic [7:0] exp_vec_q[$];
    int         exp_cyc_q[$];
    int         ref_m[N];
    logic [7:0] last_vec = 8'h00;

    neuron_step_scheduler #(
        .NUM_NEURONS (N),
        .IDX_W       (3),
        .REFRAC_STEPS(REFRAC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .step_req (step_req),
        .busy     (busy),
        .upd_valid(upd_valid),
        .upd_idx  (upd_idx),
        .upd_ready(upd_ready),
        .res_valid(res_valid),
        .res_spike(res_spike),
        .step_done(step_done),
        .spike_vec(spike_vec),
        .spike_cnt(spike_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_upd_valid"}, upd_valid, 0);
        chk({tag, "_step_done"}, step_done, 0);
        chk({tag, "_upd_idx"}, upd_idx, 0);
        chk({tag, "_spike_vec"}, spike_vec, 0);
        chk({tag, "_spike_cnt"}, spike_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; step_req = 1'b0; upd_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ref_m[i] = 0;
        last_vec = 8'h00;
        exp_idx_q.delete();
    endtask

    task automatic idle_check(input int n, input bit pulse_res);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_step_done", step_done, 0);
            chk("idle_vec_hold", spike_vec, last_vec);
            res_valid = pulse_res && (k == 0);
            res_spike = res_valid;
        end
        res_valid = 1'b0;
        res_spike = 1'b0;
    endtask

    task automatic run_step(input logic [7:0] spikes, input int stall_at, input int stall_n,
                            input bit noise, input bit req_mid);
        int         cyc, stall_left, cur, acc_idx, exp_cyc;
        logic [7:0] vec, got_vec;
        bit         fresh, acc_prev, done;
        vec = 8'h00;
        exp_cyc = 1;
        for (int i = 0; i < N; i++) begin
            if (ref_m[i] != 0) begin
                ref_m[i]--;
                exp_cyc += 1;
            end else begin
                exp_idx_q.push_back(i);
                exp_cyc += 2 + ((i == stall_at) ? stall_n : 0);
                if (spikes[i]) begin
                    vec[i] = 1'b1;
`ifdef NEURO_SCHED_REFRACTORY_EN
                    ref_m[i] = REFRAC;
`endif
                end
            end
        end
        exp_vec_q.push_back(vec);
        exp_cyc_q.push_back(exp_cyc);

        @(negedge clk);
        ena = 1'b1; step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        cyc = 1; stall_left = stall_n; fresh = 1'b1; acc_prev = 1'b0; done = 1'b0;
        cur = -1; acc_idx = 0;
        while (!done && cyc < 300) begin
            res_valid = 1'b0; res_spike = 1'b0; upd_ready = 1'b0;
            if (acc_prev) begin
                res_valid = 1'b1;
                res_spike = spikes[acc_idx];
            end
            acc_prev = 1'b0;
            if (step_done) begin
                done = 1'b1;
                chk("done_cycle", cyc, exp_cyc_q.pop_front());
                chk("done_busy", busy, 1);
                last_vec = exp_vec_q.pop_front();
                got_vec = spike_vec;
                chk("spike_vec", got_vec, last_vec);
                chk("spike_cnt", spike_cnt, $countones(last_vec));
                chk("unissued_left", exp_idx_q.size(), 0);
                $display("step done: cycle %0d spike_vec %02h spike_cnt %0d", cyc, got_vec, spike_cnt);
            end else begin
                chk("step_busy", busy, 1);
                chk("vec_hold", spike_vec, last_vec);
                if (upd_valid) begin
                    if (fresh) begin
                        cur = (exp_idx_q.size() > 0) ? exp_idx_q.pop_front() : -1;
                        fresh = 1'b0;
                    end
                    chk("upd_idx", upd_idx, cur);
                    if (cur == stall_at && stall_left > 0) begin
                        stall_left--;
                    end else begin
                        upd_ready = 1'b1;
                        acc_prev = 1'b1;
                        acc_idx = int'(upd_idx);
                        fresh = 1'b1;
                    end
                    if (noise) begin
                        res_valid = 1'b1;
                        res_spike = 1'b1;
                    end
                end
            end
            step_req = req_mid && (cyc == 5);
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk("step_done_timeout", 0, 1);
        step_req = 1'b0; upd_ready = 1'b0; res_valid = 1'b0; res_spike = 1'b0;
    endtask

    initial begin
        int  k;
        bit  found;
        bit  acc;

        for (int i = 0; i < N; i++) ref_m[i] = 0;
        do_reset();

        // basic step: spikes on neurons 2 and 5
        run_step(8'h24, -1, 0, 1'b0, 1'b0);
        idle_check(2, 1'b1);

        // backpressure at idx 4, res_valid noise during ISSUE
        run_step(8'h91, 4, 3, 1'b1, 1'b0);
        idle_check(2, 1'b0);

        // step_req mid-step must not queue a second step; all neurons spike
        run_step(8'hFF, -1, 0, 1'b0, 1'b1);
        idle_check(3, 1'b0);

        // ena low blocks step acceptance
        @(negedge clk);
        ena = 1'b0; step_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ena0_busy", busy, 0);
            chk("ena0_upd_valid", upd_valid, 0);
        end
        step_req = 1'b0; ena = 1'b1;

        // reset in the middle of a step, when idx 3 is being offered
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        found = 1'b0; acc = 1'b0; k = 0;
        while (!found && k < 60) begin
            upd_ready = 1'b0;
            res_valid = acc;
            res_spike = 1'b0;
            acc = 1'b0;
            if (upd_valid && upd_idx == 3'd3) begin
                found = 1'b1;
            end else begin
                if (upd_valid) begin
                    upd_ready = 1'b1;
                    acc = 1'b1;
                end
                @(negedge clk);
                k++;
            end
        end
        chk("reach_idx3", found, 1);
        rst_n = 1'b0; upd_ready = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        $display("reset mid-step at idx 3");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ref_m[i] = 0;
        last_vec = 8'h00;
        exp_idx_q.delete();
        idle_check(3, 1'b0);
        run_step(8'h81, -1, 0, 1'b0, 1'b0);
        idle_check(1, 1'b0);

`ifdef NEURO_SCHED_REFRACTORY_EN
        // neuron 1 spikes in step A, is skipped in B and C, reissued in D
        do_reset();
        run_step(8'h02, -1, 0, 1'b0, 1'b0);
        run_step(8'h02, -1, 0, 1'b0, 1'b0);
        run_step(8'h02, -1, 0, 1'b0, 1'b0);
        run_step(8'h02, -1, 0, 1'b0, 1'b0);
        idle_check(1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/neuron_step_scheduler.md
# neuron_step_scheduler

Time-step sequencer for the neurocore's single shared neuron-update datapath. On each step request it walks neuron indices 0..NUM_NEURONS-1 and issues one update per neuron over a valid/ready handshake. It collects each neuron's spike result and publishes the step's spike vector and spike count with a one-cycle completion pulse. It sits between the top-level `tt_um_neurocore` control/IO logic and the update datapath.

## Interface
Parameters:
- `NUM_NEURONS`, 8: neurons per step; must be ≥2.
- `IDX_W`, 3: neuron index width; must satisfy 2^IDX_W ≥ NUM_NEURONS.
- `REFRAC_STEPS`, 2: refractory length in steps (1..7). Used only with `NEURO_SCHED_REFRACTORY_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: design enable; gates step acceptance only.
- `step_req` in 1: start one time step; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `upd_valid` out 1: update request to the datapath.
- `upd_idx` out IDX_W: neuron index of the current request.
- `upd_ready` in 1: datapath accepts the request.
- `res_valid` in 1: datapath result strobe.
- `res_spike` in 1: spike result; qualified by `res_valid`.
- `step_done` out 1: one-cycle pulse when a step completes.
- `spike_vec` out NUM_NEURONS: spikes of the last completed step; bit i = neuron i.
- `spike_cnt` out IDX_W+1: popcount of `spike_vec`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. An index register `idx` and a pending vector `pend` hold per-step progress.
- **IDLE:**
  - If `step_req & ena`: clear `pend`, set `idx=0`, go to ISSUE.
  - Otherwise stay in IDLE.
  - `step_req` in any other state is ignored and not queued.
- **ISSUE:**
  - `upd_valid=1`, `upd_idx=idx`.
  - Both are held stable until `upd_valid & upd_ready`; then go to WAIT.
- **WAIT:**
  - `upd_valid=0`; wait for `res_valid`.
  - On `res_valid`: set `pend[idx]=res_spike`.
  - If `idx==NUM_NEURONS-1`, go to DONE. Otherwise increment `idx` and go to ISSUE.
- **DONE:**
  - Register `spike_vec<=pend` and `spike_cnt<=popcount(pend)`.
  - Pulse `step_done` for exactly one cycle, then go to IDLE.
- `res_valid` outside WAIT is ignored. This includes the acceptance cycle in ISSUE.
- `spike_vec`/`spike_cnt` change only on the DONE cycle and otherwise hold their values.
- Index arithmetic never wraps: `idx` ranges over 0..NUM_NEURONS-1 only.
- `ena` low does not stall an in-progress step; the step runs to DONE.
- **Reset (any state, including mid-step):**
  - State → IDLE; `idx`, `pend` → 0.
  - Outputs: `busy`, `upd_valid`, `step_done` → 0; `upd_idx`, `spike_vec`, `spike_cnt` → 0.
  - A step interrupted by reset produces no `step_done`.

## Timing
- All outputs are registered or decoded from state/registers; there are no combinational input-to-output paths.
- `step_req` sampled at edge 0 → ISSUE with `upd_valid=1` in cycle 1.
- Per neuron, minimum 2 cycles: 1 in ISSUE with `upd_ready` high, 1 in WAIT with `res_valid` high.
- Minimum step latency: `step_done` high in cycle 2·NUM_NEURONS+1 (cycle 17 at N=8). `spike_vec` is valid in the same cycle.
- Back-to-back: the earliest next `step_req` is sampled in the cycle after `step_done`, when the FSM is in IDLE.
- Each `upd_ready` stall cycle and each `res_valid` wait cycle adds exactly one cycle.

## Configuration
- Macro: `NEURO_SCHED_REFRACTORY_EN`.
- **Defined:**
  - Each neuron has a counter `ref[i]` (3 bits), reset to 0.
  - In ISSUE, if `ref[idx]!=0`, the neuron is skipped for 1 cycle:
    - no `upd_valid`;
    - `pend[idx]=0`;
    - `ref[idx]` decrements;
    - then advance as from WAIT, including the last-index check.
  - On a captured `res_spike=1`, `ref[idx]<=REFRAC_STEPS`.
- **Undefined:** no counters; every neuron is issued every step.

## Test plan
- **Basic step:** reset; `upd_ready=1`, `res_valid` one cycle after each accept; `res_spike=1` for idx 2 and 5.
  - Expect `upd_idx` sequence 0..7.
  - Expect `step_done` in cycle 17, `spike_vec=8'h24`, `spike_cnt=2`.
- **Backpressure:** hold `upd_ready=0` for 3 cycles at idx 4.
  - Expect `upd_valid`/`upd_idx=4` stable throughout.
  - Expect `step_done` at cycle 20.
- **Ignored inputs:**
  - Pulse `step_req` mid-step → no second step.
  - Pulse `res_valid` in ISSUE/IDLE → `pend` unchanged.
  - `step_req` with `ena=0` → FSM stays in IDLE, `busy=0`.
- **Reset mid-step:** drop `rst_n` at idx 3 → next cycle all outputs 0, no `step_done`. A new step then completes normally.
- **Refractory (macro defined, REFRAC_STEPS=2):** neuron 1 spikes in step A.
  - Steps B and C: neuron 1 not issued; `spike_vec[1]=0`; each step is 1 cycle shorter than with all neurons issued.
  - Step D: neuron 1 is issued again.
